game_flow_ctrl: RTL and testbench
=================================

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- STAGES, 4: number of stages, 1..2^STAGE_W.
- STAGE_W, 2: width of the stage index.
- LIVES, 3: lives at game start, 1..15.
- FADE_STEP, 2: frame ticks per brightness step.
- RST_CYCLES, 8: clk cycles world_rstn is held low per world restart.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: system clock.
- rstn, in, 1: synchronous active-low reset.
- frame_tick, in, 1: one-clk pulse per game frame.
- start, in, 1: start button level.
- over, in, 2: world status; 00 running, 01 death, 10 stage clear, 11 treated as death.
- world_rstn, out, 1: active-low reset to the world/physics block.
- stage, out, STAGE_W: current stage index.
- lives, out, 4: remaining lives.
- mask, out, 12: RGB444 colour mask to the video output.
- state, out, 3: FSM state code.
- life_lost, out, 1: one-clk event pulse.
- stage_up, out, 1: one-clk event pulse.

Function
REQ-003 States and codes: IDLE=0, RESTART=1, PLAY=2, FADE=3, GAME_OVER=4, WIN=5; state output equals the current code.

REQ-004 start is registered, and a rising edge (start_q=0, start=1) forms a one-clk start_p; a held level never forms a second start_p.

REQ-005 IDLE: world_rstn=0, mask=12'hFFF; on start_p load stage=0, lives=LIVES, then go to RESTART.

REQ-006 RESTART: world_rstn=0 for exactly RST_CYCLES clks counted from entry, then go to PLAY; over, frame_tick and start are ignored.

REQ-007 PLAY: world_rstn=1, mask=12'hFFF.
- Any clk with over!=00: go to FADE and latch cause (clear if over==10, else death).
- start is ignored.

REQ-008 FADE: world_rstn=1 and mask={lvl,lvl,lvl}, with lvl a 4-bit level set to 15 on entry.
- Each frame_tick increments step_cnt.
- When step_cnt==FADE_STEP-1 on a tick, step_cnt clears and lvl decrements.
- lvl saturates at 0.
- over changes during FADE are ignored.

REQ-009 FADE exit occurs on the first frame_tick at which lvl is already 0. With defaults this is the 31st tick after entry. At exit:
- death and lives>1: lives-1, life_lost=1 for one clk, go to RESTART.
- death and lives==1: lives=0, life_lost=1, go to GAME_OVER.
- clear and stage<STAGES-1: stage+1, stage_up=1 for one clk, go to RESTART.
- clear and stage==STAGES-1: stage unchanged, stage_up=1, go to WIN.

REQ-010 GAME_OVER: world_rstn=0, mask=12'hF00. WIN: world_rstn=0, mask=12'h0F0. In both, start_p reloads stage=0 and lives=LIVES and goes to RESTART.

REQ-011 stage never exceeds STAGES-1 and lives never wraps below 0; all arithmetic is unsigned at the declared widths.

REQ-012 All outputs are registered. Event pulses are asserted in the same clk as the corresponding state change and are never asserted simultaneously.

REQ-013 A frame_tick coinciding with the FADE entry clk is not counted; counting starts the following clk.

Reset
REQ-014 With rstn=0 at a clk edge, the following apply, whatever the current state:
- state=IDLE, stage=0, lives=LIVES, mask=12'hFFF, world_rstn=0.
- life_lost=0, stage_up=0, all counters 0, lvl=15, start_q=1.
- Setting start_q=1 means a start held through reset does not trigger a game.

REQ-015 Reset asserted mid-FADE or mid-RESTART abandons the operation with no event pulse.

Verification (defaults)
REQ-016 Reset then start 0->1:
- state becomes RESTART, world_rstn low for exactly 8 clks, then PLAY with world_rstn=1, stage=0, lives=3.

REQ-017 In PLAY, over=01, then frame_tick every 4 clks:
- mask steps FFF, EEE, ... 000, changing every 2 ticks.
- On tick 31: lives=2, one-clk life_lost, state RESTART.

REQ-018 Three successive deaths:
- The third FADE exit gives lives=0, state GAME_OVER, mask=F00.
- start held high gives no restart; a release and press gives RESTART with lives=3, stage=0.

REQ-019 Four successive clears (over=10):
- stage 0->1->2->3 with stage_up each time.
- The fourth clear gives state WIN, stage=3, mask=0F0.

REQ-020 Boundary cases:
- over=11 behaves as death.
- over toggled back to 00 mid-FADE does not alter the outcome.
- start pressed during PLAY/FADE is ignored.
- rstn=0 mid-FADE returns to IDLE with mask=FFF and no pulse.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: game sequencing FSM (idle, world restart, play, fade-out, game over, win).
// Ports: clk/rstn (sync active-low reset), frame_tick (one pulse per frame), start (button level),
//        over (world status: 00 running, 01 death, 10 clear, 11 death), world_rstn (active-low
//        world reset), stage/lives (progress), mask (RGB444 video mask), state (FSM code),
//        life_lost/stage_up (one-clk event pulses). All outputs are registered.
module game_flow_ctrl #(
    parameter int STAGES     = 4,
    parameter int STAGE_W    = 2,
    parameter int LIVES      = 3,
    parameter int FADE_STEP  = 2,
    parameter int RST_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               frame_tick,
    input  logic               start,
    input  logic [1:0]         over,
    output logic               world_rstn,
    output logic [STAGE_W-1:0] stage,
    output logic [3:0]         lives,
    output logic [11:0]        mask,
    output logic [2:0]         state,
    output logic               life_lost,
    output logic               stage_up
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESTART   = 3'd1,
        PLAY      = 3'd2,
        FADE      = 3'd3,
        GAME_OVER = 3'd4,
        WIN       = 3'd5
    } state_t;

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int FW = $clog2(FADE_STEP + 1);
    localparam logic [STAGE_W-1:0] LAST   = STAGE_W'(STAGES - 1);
    localparam logic [3:0]         LIVES4 = 4'(LIVES);

    state_t        st;
    logic          start_q;
    logic          clear;
    logic [RW-1:0] rst_cnt;
    logic [FW-1:0] step_cnt;
    logic [3:0]    lvl;
    logic          start_p;

    assign start_p = start & ~start_q;
    assign state   = st;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            st         <= IDLE;
            start_q    <= 1'b1;
            clear      <= 1'b0;
            rst_cnt    <= '0;
            step_cnt   <= '0;
            lvl        <= 4'hF;
            stage      <= '0;
            lives      <= LIVES4;
            mask       <= 12'hFFF;
            world_rstn <= 1'b0;
            life_lost  <= 1'b0;
            stage_up   <= 1'b0;
        end else begin
            start_q   <= start;
            life_lost <= 1'b0;
            stage_up  <= 1'b0;
            case (st)
                IDLE, GAME_OVER, WIN: begin
                    if (start_p) begin
                        stage      <= '0;
                        lives      <= LIVES4;
                        st         <= RESTART;
                        rst_cnt    <= '0;
                        mask       <= 12'hFFF;
                        world_rstn <= 1'b0;
                    end
                end
                RESTART: begin
                    if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                        st         <= PLAY;
                        world_rstn <= 1'b1;
                        mask       <= 12'hFFF;
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end
                PLAY: begin
                    if (over != 2'b00) begin
                        st       <= FADE;
                        clear    <= (over == 2'b10);
                        lvl      <= 4'hF;
                        step_cnt <= '0;
                        mask     <= 12'hFFF;
                    end
                end
                FADE: begin
                    if (frame_tick) begin
                        // Exit only on a tick that finds the fade already fully dark.
                        if (lvl == 4'd0) begin
                            world_rstn <= 1'b0;
                            rst_cnt    <= '0;
                            if (!clear) begin
                                life_lost <= 1'b1;
                                if (lives > 4'd1) begin
                                    lives <= lives - 4'd1;
                                    st    <= RESTART;
                                    mask  <= 12'hFFF;
                                end else begin
                                    lives <= 4'd0;
                                    st    <= GAME_OVER;
                                    mask  <= 12'hF00;
                                end
                            end else begin
                                stage_up <= 1'b1;
                                if (stage < LAST) begin
                                    stage <= stage + STAGE_W'(1);
                                    st    <= RESTART;
                                    mask  <= 12'hFFF;
                                end else begin
                                    st   <= WIN;
                                    mask <= 12'h0F0;
                                end
                            end
                        end else if (step_cnt == FW'(FADE_STEP - 1)) begin
                            step_cnt <= '0;
                            lvl      <= lvl - 4'd1;
                            mask     <= {3{lvl - 4'd1}};
                        end else begin
                            step_cnt <= step_cnt + FW'(1);
                        end
                    end
                end
                default: begin
                    st         <= IDLE;
                    mask       <= 12'hFFF;
                    world_rstn <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: randomized and directed checks of game_flow_ctrl against a frame-counting reference model.
module tb_game_flow_ctrl;
    localparam int STAGES     = 4;
    localparam int STAGE_W    = 2;
    localparam int LIVES      = 3;
    localparam int FADE_STEP  = 2;
    localparam int RST_CYCLES = 8;
    localparam int EXIT_TICK  = 15 * FADE_STEP + 1;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               frame_tick = 1'b0;
    logic               start = 1'b0;
    logic [1:0]         over = 2'b00;
    logic               world_rstn;
    logic [STAGE_W-1:0] stage;
    logic [3:0]         lives;
    logic [11:0]        mask;
    logic [2:0]         state;
    logic               life_lost;
    logic               stage_up;

    int total = 0;
    int bad = 0;

    int m_state, m_stage, m_lives, m_elapsed, m_ticks;
    logic m_prev, m_clear, m_ll, m_su;

    game_flow_ctrl #(
        .STAGES(STAGES), .STAGE_W(STAGE_W), .LIVES(LIVES),
        .FADE_STEP(FADE_STEP), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk(clk), .rstn(rstn), .frame_tick(frame_tick), .start(start), .over(over),
        .world_rstn(world_rstn), .stage(stage), .lives(lives), .mask(mask),
        .state(state), .life_lost(life_lost), .stage_up(stage_up)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] obs();
        return {state, stage, lives, (m_state == 1) ? 12'h000 : mask, world_rstn, life_lost, stage_up};
    endfunction

    function automatic logic [23:0] expv();
        int l;
        logic [11:0] mm;
        l  = 15 - m_ticks / FADE_STEP;
        l  = (l < 0) ? 0 : l;
        mm = (m_state == 3) ? {3{4'(l)}} : (m_state == 4) ? 12'hF00 : (m_state == 5) ? 12'h0F0 :
             (m_state == 1) ? 12'h000 : 12'hFFF;
        return {3'(m_state), 2'(m_stage), 4'(m_lives), mm, (m_state == 2 || m_state == 3), m_ll, m_su};
    endfunction

    task automatic enter_restart();
        m_state   = 1;
        m_elapsed = 0;
    endtask

    task automatic step(input logic t, input logic [1:0] ov, input logic s, input logic r);
        logic sp;
        frame_tick = t;
        over       = ov;
        start      = s;
        rstn       = r;
        @(posedge clk);
        m_ll = 1'b0;
        m_su = 1'b0;
        if (!r) begin
            m_state = 0;
            m_stage = 0;
            m_lives = LIVES;
            m_prev  = 1'b1;
        end else begin
            sp     = s && !m_prev;
            m_prev = s;
            case (m_state)
                0, 4, 5: if (sp) begin
                    m_stage = 0;
                    m_lives = LIVES;
                    enter_restart();
                end
                1: begin
                    m_elapsed++;
                    if (m_elapsed == RST_CYCLES) m_state = 2;
                end
                2: if (ov != 2'b00) begin
                    m_state = 3;
                    m_clear = (ov == 2'b10);
                    m_ticks = 0;
                end
                3: if (t) begin
                    m_ticks++;
                    if (m_ticks == EXIT_TICK) begin
                        if (!m_clear) begin
                            m_ll = 1'b1;
                            if (m_lives > 1) begin
                                m_lives--;
                                enter_restart();
                            end else begin
                                m_lives = 0;
                                m_state = 4;
                            end
                        end else begin
                            m_su = 1'b1;
                            if (m_stage < STAGES - 1) begin
                                m_stage++;
                                enter_restart();
                            end else m_state = 5;
                        end
                    end
                end
                default: m_state = 0;
            endcase
        end
        #1;
    endtask

    task automatic wait_play();
        for (int i = 0; i < RST_CYCLES; i++) begin
            step(1'b0, 2'($urandom), 1'b0, 1'b1);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL restart_wait: got %h exp %h", obs(), expv());
            end
        end
    endtask

    task automatic to_play();
        step(1'b0, 2'b00, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b1, 1'b1);
        wait_play();
    endtask

    task automatic do_fade(input logic [1:0] ov, input logic s, output int ticks, output int ll, output int su);
        logic t;
        ticks = 0;
        ll    = 0;
        su    = 0;
        step(1'b1, ov, s, 1'b1);
        for (int c = 0; c < 400 && state == 3'd3; c++) begin
            t = (c % 4 == 3);
            step(t, 2'($urandom), s, 1'b1);
            ticks += int'(t);
            ll    += int'(life_lost);
            su    += int'(stage_up);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL fade_cycle %0d: got %h exp %h", c, obs(), expv());
            end
        end
    endtask

    task automatic test_reset();
        step(1'b0, 2'b00, 1'b1, 1'b0);
        step(1'b1, 2'b01, 1'b1, 1'b0);
        total++;
        if ({state, stage, lives, mask, world_rstn, life_lost, stage_up} !== {3'd0, 2'd0, 4'd3, 12'hFFF, 3'b000}) begin
            bad++;
            $display("FAIL reset_values: got %h", {state, stage, lives, mask, world_rstn, life_lost, stage_up});
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b00, 1'b1, 1'b1);
            total++;
            if (state !== 3'd0 || obs() !== expv()) begin
                bad++;
                $display("FAIL start_held_through_reset: got %h exp %h", obs(), expv());
            end
        end
    endtask

    task automatic test_start();
        int lowcnt = 0;
        step(1'b0, 2'b00, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b1, 1'b1);
        for (int i = 0; i < RST_CYCLES + 4; i++) begin
            if (state == 3'd1 && world_rstn == 1'b0) lowcnt++;
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL start_restart: got %h exp %h", obs(), expv());
            end
            step(1'b0, 2'b00, 1'b1, 1'b1);
        end
        total++;
        if (lowcnt != RST_CYCLES || {state, world_rstn, stage, lives} !== {3'd2, 1'b1, 2'd0, 4'd3}) begin
            bad++;
            $display("FAIL restart_len: low=%0d need %0d, state=%0d wr=%b", lowcnt, RST_CYCLES, state, world_rstn);
        end
    endtask

    task automatic test_play_start_ignored();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 2'b00, logic'(i % 2), 1'b1);
            total++;
            if (state !== 3'd2 || obs() !== expv()) begin
                bad++;
                $display("FAIL play_start_ignored: got %h exp %h", obs(), expv());
            end
        end
    endtask

    task automatic test_death();
        int tk, ll, su;
        do_fade(2'b01, 1'b1, tk, ll, su);
        total++;
        if (tk != EXIT_TICK || ll != 1 || su != 0 || lives !== 4'd2 || state !== 3'd1) begin
            bad++;
            $display("FAIL death_exit: ticks=%0d ll=%0d su=%0d lives=%0d state=%0d need %0d/1/0/2/1", tk, ll, su, lives, state, EXIT_TICK);
        end
    endtask

    task automatic test_game_over();
        int tk, ll, su;
        wait_play();
        do_fade(2'b11, 1'b0, tk, ll, su);
        total++;
        if (ll != 1 || lives !== 4'd1 || state !== 3'd1) begin
            bad++;
            $display("FAIL death_11: ll=%0d lives=%0d state=%0d need 1/1/1", ll, lives, state);
        end
        wait_play();
        do_fade(2'b01, 1'b1, tk, ll, su);
        total++;
        if (ll != 1 || {state, lives, mask, world_rstn} !== {3'd4, 4'd0, 12'hF00, 1'b0}) begin
            bad++;
            $display("FAIL game_over: ll=%0d state=%0d lives=%0d mask=%h", ll, state, lives, mask);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'b00, 1'b1, 1'b1);
            total++;
            if (state !== 3'd4 || obs() !== expv()) begin
                bad++;
                $display("FAIL go_held_start: got %h exp %h", obs(), expv());
            end
        end
        step(1'b0, 2'b00, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b1, 1'b1);
        total++;
        if ({state, lives, stage} !== {3'd1, 4'd3, 2'd0} || obs() !== expv()) begin
            bad++;
            $display("FAIL go_restart: got %h exp %h", obs(), expv());
        end
    endtask

    task automatic test_clears();
        int tk, ll, su;
        for (int i = 0; i < STAGES; i++) begin
            wait_play();
            do_fade(2'b10, 1'b0, tk, ll, su);
            total++;
            if (su != 1 || ll != 0 || stage !== 2'(i < STAGES - 1 ? i + 1 : STAGES - 1) ||
                state !== ((i < STAGES - 1) ? 3'd1 : 3'd5)) begin
                bad++;
                $display("FAIL clear_%0d: su=%0d ll=%0d stage=%0d state=%0d", i, su, ll, stage, state);
            end
        end
        total++;
        if ({state, stage, mask, world_rstn} !== {3'd5, 2'd3, 12'h0F0, 1'b0}) begin
            bad++;
            $display("FAIL win: state=%0d stage=%0d mask=%h wr=%b", state, stage, mask, world_rstn);
        end
        step(1'b0, 2'b00, 1'b1, 1'b1);
        total++;
        if ({state, lives, stage} !== {3'd1, 4'd3, 2'd0}) begin
            bad++;
            $display("FAIL win_restart: state=%0d lives=%0d stage=%0d", state, lives, stage);
        end
    endtask

    task automatic test_reset_mid();
        wait_play();
        step(1'b0, 2'b01, 1'b0, 1'b1);
        repeat (9) step(1'b1, 2'b00, 1'b0, 1'b1);
        step(1'b1, 2'b00, 1'b0, 1'b0);
        total++;
        if ({state, mask, world_rstn, life_lost, stage_up} !== {3'd0, 12'hFFF, 3'b000} || obs() !== expv()) begin
            bad++;
            $display("FAIL reset_mid_fade: got %h exp %h", obs(), expv());
        end
        step(1'b0, 2'b00, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b1, 1'b1);
        repeat (3) step(1'b0, 2'b00, 1'b1, 1'b1);
        step(1'b0, 2'b00, 1'b1, 1'b0);
        total++;
        if ({state, life_lost, stage_up} !== {3'd0, 2'b00} || obs() !== expv()) begin
            bad++;
            $display("FAIL reset_mid_restart: got %h exp %h", obs(), expv());
        end
    endtask

    task automatic test_random();
        logic s = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            s = ($urandom_range(0, 9) == 0) ? ~s : s;
            step($urandom_range(0, 2) == 0,
                 ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00,
                 s, $urandom_range(0, 399) != 0);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL random_%0d: got %h exp %h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_play_start_ignored();
        test_death();
        test_game_over();
        test_clears();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
